hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the integer/float pipeline. Owns a register scoreboard of pending

---
 rtl/hazard_ctrl_pkg.sv | 19 +
 rtl/hazard_ctrl_if.sv | 38 +++
 rtl/hazard_ctrl_reg_scoreboard.sv | 45 ++++
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

    localparam int MC_MAX_WAIT = 4;

    // Register address: 0..31 are architectural registers, NO_REG marks an unused slot.
    typedef logic [5:0] reg_add_e;
    localparam reg_add_e NO_REG = 6'h3f;

    typedef enum logic [1:0] {NO_WB, WB_ALU, WB_MEM, WB_MC} wb_sel_e;

    typedef enum logic [1:0] {HZ_RUN, HZ_DRAIN, HZ_DONE} hazard_state_e;

    // True when the address names a real register of a file with nregs entries.
    function automatic logic reg_valid(input reg_add_e r, input int nregs);
        return (r != NO_REG) && (int'(r) < nregs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    reg_add_e rs1_i, rs2_i;
    reg_add_e rs1_float_i, rs2_float_i, rs3_float_i;
    reg_add_e rd_ex_i, rd_float_ex_i;
    wb_sel_e  wb_ex_i;
    logic     load_ex_i;
    wb_sel_e  wb_wb_i;
    logic     mc_issue_i;
    reg_add_e mc_rd_i;
    logic     mc_float_i;
    logic     mc_done_i;
    reg_add_e mc_done_rd_i;
    logic     mc_done_float_i;
    logic     drain_req_i;
    logic     stall_id_o;
    logic     freeze_o;
    logic     mc_grant_o;
    logic     drain_done_o;

    modport master (
        output rs1_i, rs2_i, rs1_float_i, rs2_float_i, rs3_float_i,
        output rd_ex_i, rd_float_ex_i, wb_ex_i, load_ex_i, wb_wb_i,
        output mc_issue_i, mc_rd_i, mc_float_i,
        output mc_done_i, mc_done_rd_i, mc_done_float_i, drain_req_i,
        input  stall_id_o, freeze_o, mc_grant_o, drain_done_o
    );

    modport slave (
        input  rs1_i, rs2_i, rs1_float_i, rs2_float_i, rs3_float_i,
        input  rd_ex_i, rd_float_ex_i, wb_ex_i, load_ex_i, wb_wb_i,
        input  mc_issue_i, mc_rd_i, mc_float_i,
        input  mc_done_i, mc_done_rd_i, mc_done_float_i, drain_req_i,
        output stall_id_o, freeze_o, mc_grant_o, drain_done_o
    );
endinterface

// File: rtl/hazard_ctrl_reg_scoreboard.sv
// Pending-write bit vector with one set port, one clear port and three lookups.
module reg_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int NREGS     = 32,
    parameter bit HARD_ZERO = 1'b1   // register 0 is hardwired and never pending
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  reg_add_e         set_rd,
    input  logic             clr_en,
    input  reg_add_e         clr_rd,
    input  reg_add_e [2:0]   look_rd,
    output logic [2:0]       hit,
    output logic [NREGS-1:0] pend,
    output logic             empty
);
    localparam int IW = $clog2(NREGS);

    logic [NREGS-1:0] bits;

    // Clear first, then set, so a same-cycle set on the retiring register stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            bits <= '0;
        end else begin
            if (clr_en && reg_valid(clr_rd, NREGS))
                bits[clr_rd[IW-1:0]] <= 1'b0;
            if (set_en && reg_valid(set_rd, NREGS) && !(HARD_ZERO && set_rd == '0))
                bits[set_rd[IW-1:0]] <= 1'b1;
        end
    end

    // Lookups read the current (pre-update) bits.
    always_comb begin
        hit = '0;
        for (int i = 0; i < 3; i++)
            hit[i] = reg_valid(look_rd[i], NREGS) && bits[look_rd[i][IW-1:0]];
    end

    assign pend  = bits;
    assign empty = (bits == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use / scoreboard stalls, write-port arbitration, drain sequencing.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = MC_MAX_WAIT,
    parameter int NREGS    = 32
) (
    input  logic          clk_i,
    input  logic          reset_i,
    hazard_ctrl_if.slave  hz
);
    localparam int IW = $clog2(NREGS);
    localparam int CW = $clog2(MAX_WAIT + 1);

    hazard_state_e    state, state_nxt;
    logic [CW-1:0]    wait_cnt;
    logic             at_max, wb_busy, grant, freeze;
    logic             stall_raw, issue_ok;
    logic [2:0]       hit_int, hit_fp;
    logic [NREGS-1:0] pend_int;
    logic             empty_int, empty_fp;
    logic             lu_int, lu_fp, waw_int, waw_fp;

    // Write port: idle WB yields immediately; otherwise a starved result forces a freeze.
    assign at_max  = (wait_cnt == CW'(MAX_WAIT));
    assign wb_busy = (hz.wb_wb_i != NO_WB);
    assign grant   = hz.mc_done_i && (!wb_busy || at_max);
    assign freeze  = hz.mc_done_i && at_max;

    // Wait counter counts starved cycles, clears on grant or when no result is waiting.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            wait_cnt <= '0;
        else if (grant || !hz.mc_done_i)
            wait_cnt <= '0;
        else if (!at_max)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // A frozen pipe is not advancing, so the issuing op is not accepted either.
    assign issue_ok = hz.mc_issue_i && !stall_raw && !freeze;

    reg_scoreboard #(.NREGS(NREGS), .HARD_ZERO(1'b1)) u_sb_int (
        .clk(clk_i), .rst(reset_i),
        .set_en(issue_ok && !hz.mc_float_i), .set_rd(hz.mc_rd_i),
        .clr_en(grant && !hz.mc_done_float_i), .clr_rd(hz.mc_done_rd_i),
        .look_rd({NO_REG, hz.rs2_i, hz.rs1_i}),
        .hit(hit_int), .pend(pend_int), .empty(empty_int)
    );

    // WAW: the retiring register is already being written this cycle, so it is not a hazard.
    assign waw_int = hz.mc_issue_i && !hz.mc_float_i && reg_valid(hz.mc_rd_i, NREGS)
                   && pend_int[hz.mc_rd_i[IW-1:0]]
                   && !(grant && !hz.mc_done_float_i && hz.mc_done_rd_i == hz.mc_rd_i);

    assign lu_int = hz.load_ex_i && (hz.wb_ex_i != NO_WB) && (hz.rd_ex_i != '0)
                  && (hz.rd_ex_i != NO_REG)
                  && (hz.rd_ex_i == hz.rs1_i || hz.rd_ex_i == hz.rs2_i);

`ifdef FPU
    logic [NREGS-1:0] pend_fp;

    reg_scoreboard #(.NREGS(NREGS), .HARD_ZERO(1'b0)) u_sb_fp (
        .clk(clk_i), .rst(reset_i),
        .set_en(issue_ok && hz.mc_float_i), .set_rd(hz.mc_rd_i),
        .clr_en(grant && hz.mc_done_float_i), .clr_rd(hz.mc_done_rd_i),
        .look_rd({hz.rs3_float_i, hz.rs2_float_i, hz.rs1_float_i}),
        .hit(hit_fp), .pend(pend_fp), .empty(empty_fp)
    );

    assign waw_fp = hz.mc_issue_i && hz.mc_float_i && reg_valid(hz.mc_rd_i, NREGS)
                  && pend_fp[hz.mc_rd_i[IW-1:0]]
                  && !(grant && hz.mc_done_float_i && hz.mc_done_rd_i == hz.mc_rd_i);

    assign lu_fp = hz.load_ex_i && (hz.wb_ex_i != NO_WB) && (hz.rd_float_ex_i != NO_REG)
                 && (hz.rd_float_ex_i == hz.rs1_float_i || hz.rd_float_ex_i == hz.rs2_float_i
                     || hz.rd_float_ex_i == hz.rs3_float_i);
`else
    logic unused_fp;
    assign unused_fp = ^{hz.rs1_float_i, hz.rs2_float_i, hz.rs3_float_i, hz.rd_float_ex_i};
    assign hit_fp    = '0;
    assign empty_fp  = 1'b1;
    assign waw_fp    = 1'b0;
    assign lu_fp     = 1'b0;
`endif

    assign stall_raw = lu_int || lu_fp || (|hit_int) || (|hit_fp) || waw_int || waw_fp
                     || (state == HZ_DRAIN);

    assign hz.stall_id_o = stall_raw && !freeze;
    assign hz.freeze_o   = freeze;
    assign hz.mc_grant_o = grant;

    // Drain FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            state <= HZ_RUN;
        else
            state <= state_nxt;
    end

    // Drain FSM next state and done flag.
    always_comb begin
        state_nxt       = state;
        hz.drain_done_o = 1'b0;
        case (state)
            HZ_RUN:   if (hz.drain_req_i) state_nxt = HZ_DRAIN;
            HZ_DRAIN: begin
                if (!hz.drain_req_i)
                    state_nxt = HZ_RUN;
                else if (empty_int && empty_fp && !hz.mc_done_i)
                    state_nxt = HZ_DONE;
            end
            HZ_DONE: begin
                hz.drain_done_o = 1'b1;
                if (!hz.drain_req_i) state_nxt = HZ_RUN;
            end
            default:  state_nxt = HZ_RUN;
        endcase
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (integer path, MAX_WAIT=4).
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if hif();

    hazard_ctrl #(.MAX_WAIT(4), .NREGS(32)) dut (
        .clk_i(clk), .reset_i(rst), .hz(hif)
    );

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        reg_add_e rs1, rs2, rd_ex;
        wb_sel_e  wb_ex;
        logic     load_ex, mc_done;
        wb_sel_e  wb_wb;
        logic     e_stall, e_grant, e_freeze;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic idle();
        hif.rs1_i = NO_REG; hif.rs2_i = NO_REG;
        hif.rs1_float_i = NO_REG; hif.rs2_float_i = NO_REG; hif.rs3_float_i = NO_REG;
        hif.rd_ex_i = NO_REG; hif.rd_float_ex_i = NO_REG;
        hif.wb_ex_i = NO_WB; hif.load_ex_i = 1'b0; hif.wb_wb_i = NO_WB;
        hif.mc_issue_i = 1'b0; hif.mc_rd_i = NO_REG; hif.mc_float_i = 1'b0;
        hif.mc_done_i = 1'b0; hif.mc_done_rd_i = NO_REG; hif.mc_done_float_i = 1'b0;
        hif.drain_req_i = 1'b0;
    endtask

    task automatic outs0(input string nm);
        check({nm, " stall"}, hif.stall_id_o, 0);
        check({nm, " freeze"}, hif.freeze_o, 0);
        check({nm, " grant"}, hif.mc_grant_o, 0);
        check({nm, " done"}, hif.drain_done_o, 0);
    endtask

    // One cycle issuing a multicycle op to r with no ID sources.
    task automatic issue(input reg_add_e r);
        @(negedge clk); idle();
        hif.mc_issue_i = 1'b1; hif.mc_rd_i = r;
        #1 check($sformatf("issue x%0d stall", r), hif.stall_id_o, 0);
    endtask

    // One cycle completing r with WB idle.
    task automatic retire(input reg_add_e r, input logic drain);
        @(negedge clk); idle();
        hif.drain_req_i = drain; hif.mc_done_i = 1'b1; hif.mc_done_rd_i = r;
        #1 check($sformatf("retire x%0d grant", r), hif.mc_grant_o, 1);
    endtask

    initial begin
        int nstall;

        vecs[0] = '{6'd5,   NO_REG, 6'd5,   WB_MEM, 1'b1, 1'b0, NO_WB,  1'b1, 1'b0, 1'b0};
        vecs[1] = '{6'd5,   NO_REG, NO_REG, NO_WB,  1'b0, 1'b0, NO_WB,  1'b0, 1'b0, 1'b0};
        vecs[2] = '{6'd0,   NO_REG, 6'd0,   WB_MEM, 1'b1, 1'b0, NO_WB,  1'b0, 1'b0, 1'b0};
        vecs[3] = '{NO_REG, 6'd5,   6'd5,   WB_MEM, 1'b1, 1'b0, NO_WB,  1'b1, 1'b0, 1'b0};
        vecs[4] = '{6'd5,   NO_REG, 6'd5,   NO_WB,  1'b1, 1'b0, NO_WB,  1'b0, 1'b0, 1'b0};
        vecs[5] = '{6'd5,   6'd7,   6'd6,   WB_MEM, 1'b1, 1'b0, NO_WB,  1'b0, 1'b0, 1'b0};
        vecs[6] = '{NO_REG, NO_REG, NO_REG, NO_WB,  1'b0, 1'b1, NO_WB,  1'b0, 1'b1, 1'b0};
        vecs[7] = '{NO_REG, NO_REG, NO_REG, NO_WB,  1'b0, 1'b1, WB_ALU, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{6'd5,   NO_REG, 6'd5,   WB_ALU, 1'b0, 1'b0, WB_ALU, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{NO_REG, NO_REG, NO_REG, WB_MEM, 1'b1, 1'b0, NO_WB,  1'b0, 1'b0, 1'b0};

        // Reset state
        rst = 1'b1; idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 outs0("reset");

        // Combinational vectors: load-use and immediate grant
        foreach (vecs[i]) begin
            @(negedge clk); idle();
            hif.rs1_i = vecs[i].rs1; hif.rs2_i = vecs[i].rs2; hif.rd_ex_i = vecs[i].rd_ex;
            hif.wb_ex_i = vecs[i].wb_ex; hif.load_ex_i = vecs[i].load_ex;
            hif.mc_done_i = vecs[i].mc_done; hif.wb_wb_i = vecs[i].wb_wb;
            #1;
            check($sformatf("vec%0d stall", i), hif.stall_id_o, vecs[i].e_stall);
            check($sformatf("vec%0d grant", i), hif.mc_grant_o, vecs[i].e_grant);
            check($sformatf("vec%0d freeze", i), hif.freeze_o, vecs[i].e_freeze);
        end

        // Divide to x7, ID reads x7, done on the 10th cycle
        issue(6'd7);
        nstall = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); idle();
            hif.rs1_i = 6'd7;
            if (k == 10) begin hif.mc_done_i = 1'b1; hif.mc_done_rd_i = 6'd7; end
            #1;
            if (hif.stall_id_o) nstall++;
            check($sformatf("div grant c%0d", k), hif.mc_grant_o, (k == 10));
        end
        check("div stall cycles", nstall, 10);
        @(negedge clk); idle(); hif.rs1_i = 6'd7;
        #1 check("div stall released", hif.stall_id_o, 0);

        // Starved result with a load-use in ID: freeze on the 5th cycle overrides the stall
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk); idle();
            hif.mc_done_i = 1'b1; hif.mc_done_rd_i = NO_REG; hif.wb_wb_i = WB_ALU;
            hif.load_ex_i = 1'b1; hif.wb_ex_i = WB_MEM; hif.rd_ex_i = 6'd5; hif.rs1_i = 6'd5;
            #1;
            check($sformatf("starve grant c%0d", k), hif.mc_grant_o, (k == 5));
            check($sformatf("starve freeze c%0d", k), hif.freeze_o, (k == 5));
            check($sformatf("starve stall c%0d", k), hif.stall_id_o, (k != 5));
        end
        @(negedge clk); idle();

        // Same-cycle issue and retire of x9: set wins
        issue(6'd9);
        @(negedge clk); idle();
        hif.mc_issue_i = 1'b1; hif.mc_rd_i = 6'd9;
        #1 check("waw pending stall", hif.stall_id_o, 1);
        @(negedge clk); idle();
        hif.mc_issue_i = 1'b1; hif.mc_rd_i = 6'd9;
        hif.mc_done_i = 1'b1; hif.mc_done_rd_i = 6'd9;
        #1;
        check("set+clr grant", hif.mc_grant_o, 1);
        check("set+clr stall", hif.stall_id_o, 0);
        @(negedge clk); idle(); hif.rs1_i = 6'd9;
        #1 check("x9 still pending", hif.stall_id_o, 1);
        retire(6'd9, 1'b0);
        @(negedge clk); idle(); hif.rs1_i = 6'd9;
        #1 check("x9 cleared", hif.stall_id_o, 0);

        // x0 is never marked pending
        issue(6'd0);
        @(negedge clk); idle(); hif.rs1_i = 6'd0;
        #1 check("x0 never pending", hif.stall_id_o, 0);

        // Drain with two pending ops
        issue(6'd3);
        issue(6'd4);
        @(negedge clk); idle(); hif.drain_req_i = 1'b1;
        #1 check("drain run stall", hif.stall_id_o, 0);
        @(negedge clk); idle(); hif.drain_req_i = 1'b1;
        #1;
        check("drain stall", hif.stall_id_o, 1);
        check("drain not done", hif.drain_done_o, 0);
        retire(6'd3, 1'b1);
        retire(6'd4, 1'b1);
        @(negedge clk); idle(); hif.drain_req_i = 1'b1;
        #1 check("drain empty still draining", hif.drain_done_o, 0);
        @(negedge clk); idle(); hif.drain_req_i = 1'b1;
        #1;
        check("drain done", hif.drain_done_o, 1);
        check("drain done no stall", hif.stall_id_o, 0);
        @(negedge clk); idle();
        #1 check("drain drop done held", hif.drain_done_o, 1);
        @(negedge clk); idle();
        #1 check("back to run", hif.drain_done_o, 0);

        // Request dropped mid-drain returns to RUN
        issue(6'd3);
        @(negedge clk); idle(); hif.drain_req_i = 1'b1;
        @(negedge clk); idle(); hif.drain_req_i = 1'b1;
        #1 check("abort drain stall", hif.stall_id_o, 1);
        @(negedge clk); idle();
        @(negedge clk); idle();
        #1 check("abort back to run", hif.stall_id_o, 0);
        retire(6'd3, 1'b0);

        // Reset with 3 pending bits while draining
        issue(6'd1);
        issue(6'd2);
        issue(6'd6);
        @(negedge clk); idle(); hif.drain_req_i = 1'b1;
        @(negedge clk); idle(); hif.drain_req_i = 1'b1;
        #1 check("pre-reset drain stall", hif.stall_id_o, 1);
        @(negedge clk); idle(); rst = 1'b1;
        @(negedge clk); idle(); rst = 1'b0;
        #1 outs0("post-reset");
        @(negedge clk); idle(); hif.rs1_i = 6'd1; hif.rs2_i = 6'd2;
        #1 check("post-reset bits clear", hif.stall_id_o, 0);
        @(negedge clk); idle(); hif.drain_req_i = 1'b1;
        @(negedge clk); idle(); hif.drain_req_i = 1'b1;
        @(negedge clk); idle(); hif.drain_req_i = 1'b1;
        #1 check("post-reset drain completes", hif.drain_done_o, 1);
        @(negedge clk); idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
